// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the multiplexed seven-segment display driver.
// All display constants are active-low: a 1 bit means the LED or digit is off.
package seven_seg_pkg;

  typedef logic [3:0] nibble_t;

  localparam logic [7:0] SEG_OFF   = 8'hFF;
  localparam logic [3:0] ANODE_OFF = 4'b1111;

  // One-cold anode enables, indexed by digit number (digit 0 is rightmost).
  localparam logic [3:0] ANODE_SEL [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

endpackage

// File: rtl/seven_segment.sv
// Combinational hex-to-seven-segment decoder, active-low outputs, bit 0 = segment a.
// Letters b and d are shown in lower case so they stay distinct from 8 and 0.
module seven_segment
  import seven_seg_pkg::*;
(
  input  nibble_t    data,
  output logic [6:0] segment
);

  always_comb begin
    segment = 7'h7F;
    case (data)
      4'h0: segment = 7'h40;
      4'h1: segment = 7'h79;
      4'h2: segment = 7'h24;
      4'h3: segment = 7'h30;
      4'h4: segment = 7'h19;
      4'h5: segment = 7'h12;
      4'h6: segment = 7'h02;
      4'h7: segment = 7'h78;
      4'h8: segment = 7'h00;
      4'h9: segment = 7'h10;
      4'hA: segment = 7'h08;
      4'hB: segment = 7'h03;
      4'hC: segment = 7'h46;
      4'hD: segment = 7'h21;
      4'hE: segment = 7'h06;
      4'hF: segment = 7'h0E;
      default: segment = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seven_segment_mux.sv
// Four-digit time-multiplexed driver for a common-anode seven-segment display.
// The top two bits of a free-running refresh counter choose the digit; the outputs are registered.
module seven_segment_mux
  import seven_seg_pkg::*;
#(
  parameter int COUNT_BITS = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data,
  input  logic [3:0]  blank,
  input  logic [3:0]  dp,
  output logic [7:0]  segment,
  output logic [3:0]  anode,
  output logic        frame_tick
);

  logic [COUNT_BITS-1:0] counter_reg;
  logic [1:0]            sel;
  nibble_t               nibble;
  logic [6:0]            glyph;
  logic [7:0]            segment_next;
  logic [3:0]            anode_next;
  logic [7:0]            segment_reg;
  logic [3:0]            anode_reg;
  logic                  wrap_reg;
  logic                  frame_tick_reg;

  assign sel    = counter_reg[COUNT_BITS-1 -: 2];
  assign nibble = data[{sel, 2'b00} +: 4];

  seven_segment decoder (
    .data    (nibble),
    .segment (glyph)
  );

  always_comb begin
    segment_next = {~dp[sel], glyph};
    anode_next   = ANODE_SEL[sel];
    if (blank[sel]) begin
      segment_next = SEG_OFF;
      anode_next   = ANODE_OFF;
    end
  end

  // wrap_reg marks the cycle in which the counter sits at 0 after a real wrap, so the
  // tick lands with the first registered digit-0 output and never fires straight out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter_reg    <= '0;
      segment_reg    <= SEG_OFF;
      anode_reg      <= ANODE_OFF;
      wrap_reg       <= 1'b0;
      frame_tick_reg <= 1'b0;
    end else begin
      counter_reg    <= counter_reg + COUNT_BITS'(1);
      segment_reg    <= segment_next;
      anode_reg      <= anode_next;
      wrap_reg       <= (counter_reg == '1);
      frame_tick_reg <= wrap_reg;
    end
  end

  assign segment    = segment_reg;
  assign anode      = anode_reg;
  assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_seven_segment_mux.sv
// Randomised and directed bench for seven_segment_mux with a 4-cycle slot / 16-cycle frame.
// A cycle-count model predicts every registered output; literal checks pin the model.
module tb_seven_segment_mux;

  logic        clk;
  logic        reset;
  logic [15:0] data;
  logic [3:0]  blank;
  logic [3:0]  dp;
  logic [7:0]  segment;
  logic [3:0]  anode;
  logic        frame_tick;

  int tests;
  int fails;
  int mcnt;       // clock edges since reset release, unwrapped
  int ticks;

  seven_segment_mux #(.COUNT_BITS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .data       (data),
    .blank      (blank),
    .dp         (dp),
    .segment    (segment),
    .anode      (anode),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] hex7(input int n);
    case (n)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;  10: return 7'h08; 11: return 7'h03;
      12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // One clock: predict from the model at the edge, compare just after it, return at the negedge.
  task automatic step();
    int         digit;
    int         nib;
    logic [7:0] exp_seg;
    logic [3:0] exp_an;
    logic       exp_ft;
    @(posedge clk);
    if (reset) begin
      mcnt    = 0;
      exp_seg = 8'hFF;
      exp_an  = 4'hF;
      exp_ft  = 1'b0;
    end else begin
      digit = (mcnt % 16) / 4;
      nib   = (data >> (4 * digit)) & 15;
      if (blank[digit]) begin
        exp_seg = 8'hFF;
        exp_an  = 4'hF;
      end else begin
        exp_seg = {~dp[digit], hex7(nib)};
        exp_an  = ~(4'b0001 << digit);
      end
      exp_ft = (mcnt > 0) && (mcnt % 16 == 0);
      mcnt++;
    end
    #1;
    check("model_segment", int'(segment), int'(exp_seg));
    check("model_anode", int'(anode), int'(exp_an));
    check("model_frame_tick", int'(frame_tick), int'(exp_ft));
    $display("[TB] cyc=%0d data=%h blank=%b dp=%b seg=%h an=%b ft=%b",
             mcnt, data, blank, dp, segment, anode, frame_tick);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] lit_seg [4];
    logic [3:0] lit_an  [4];
    int hold;

    tests = 0;
    fails = 0;
    mcnt  = 0;
    reset = 1'b1;
    data  = 16'h1234;
    blank = 4'b0000;
    dp    = 4'b0000;

    // 1: reset state, then digits 4,3,2,1 in anode order 1110..0111
    step();
    step();
    check("reset_segment", int'(segment), 8'hFF);
    check("reset_anode", int'(anode), 4'hF);
    check("reset_frame_tick", int'(frame_tick), 0);
    reset = 1'b0;
    lit_seg = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    lit_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    for (int i = 0; i < 16; i++) begin
      step();
      check("t1_segment", int'(segment), int'(lit_seg[i / 4]));
      check("t1_anode", int'(anode), int'(lit_an[i / 4]));
      check("t1_no_tick", int'(frame_tick), 0);
    end

    // 2: F0A8 over two frames, one tick per frame on the digit-0 slot
    data    = 16'hF0A8;
    lit_seg = '{8'h80, 8'h88, 8'hC0, 8'h8E};
    ticks   = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      check("t2_segment", int'(segment), int'(lit_seg[(i % 16) / 4]));
      if (frame_tick) begin
        ticks++;
        check("t2_tick_anode", int'(anode), 4'b1110);
        check("t2_tick_slot_start", i % 16, 0);
      end
    end
    check("t2_tick_count", ticks, 2);

    // 3: blanking overrides dp
    data    = 16'h8888;
    blank   = 4'b0101;
    dp      = 4'b0001;
    lit_seg = '{8'hFF, 8'h80, 8'hFF, 8'h80};
    lit_an  = '{4'b1111, 4'b1101, 4'b1111, 4'b0111};
    for (int i = 0; i < 16; i++) begin
      step();
      check("t3_segment", int'(segment), int'(lit_seg[i / 4]));
      check("t3_anode", int'(anode), int'(lit_an[i / 4]));
    end

    // 4: decimal points on digits 1 and 3
    data    = 16'h0000;
    blank   = 4'b0000;
    dp      = 4'b1010;
    lit_seg = '{8'hC0, 8'h40, 8'hC0, 8'h40};
    for (int i = 0; i < 16; i++) begin
      step();
      check("t4_segment", int'(segment), int'(lit_seg[i / 4]));
    end

    // 5: mid-slot data change shows on the next edge
    data = 16'h1234;
    dp   = 4'b0000;
    for (int i = 0; i < 5; i++) step();
    check("t5_before_segment", int'(segment), 8'hB0);
    check("t5_before_anode", int'(anode), 4'b1101);
    data = 16'h1274;
    step();
    check("t5_after_segment", int'(segment), 8'hF8);
    check("t5_after_anode", int'(anode), 4'b1101);

    // 6: asynchronous reset in slot 2, then restart at digit 0
    for (int i = 0; i < 3; i++) step();
    check("t6_slot2_anode", int'(anode), 4'b1011);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_segment", int'(segment), 8'hFF);
    check("t6_async_anode", int'(anode), 4'hF);
    check("t6_async_tick", int'(frame_tick), 0);
    @(negedge clk);
    step();
    reset = 1'b0;
    step();
    check("t6_restart_segment", int'(segment), 8'h99);
    check("t6_restart_anode", int'(anode), 4'b1110);

    // Randomised inputs, checked every cycle by the model
    for (int n = 0; n < 60; n++) begin
      data  = 16'($urandom);
      blank = 4'($urandom_range(0, 15));
      dp    = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) blank = 4'b0000;
      hold = $urandom_range(1, 12);
      for (int k = 0; k < hold; k++) step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seven_segment_mux.md
Name: seven_segment_mux

Overview:
- Time-multiplexed driver for the board's 4-digit common-anode seven-segment display.
- Takes a 16-bit hex value plus per-digit blank and decimal-point controls.
- Cycles through the four anodes with a free-running refresh counter and decodes one nibble per slot.
- Output is registered and drives the segment/anode pins directly, replacing the single-digit static top.

Parameters:
- COUNT_BITS, 17, refresh counter width. Top 2 bits select the digit. Slot length is 2^(COUNT_BITS-2) cycles, 32768 cycles (~328 us) at 100 MHz. Legal range is 3 or more.

Ports:
- clk  input  1  system clock, 100 MHz on board
- reset  input  1  asynchronous, active-high reset
- data  input  16  hex digits; digit i = data[4i+3:4i], digit 0 rightmost
- blank  input  4  blank[i]=1 turns digit i fully off
- dp  input  4  dp[i]=1 lights the decimal point of digit i
- segment  output  8  active-low; [6:0]=g..a (bit0=a), [7]=dp
- anode  output  4  active-low digit enables; anode[i] drives digit i
- frame_tick  output  1  one-cycle pulse when the counter wraps to 0 (start of digit 0 slot)

Behaviour:
- Reset (async, active-high), applied immediately:
  - counter=0
  - segment=8'hFF, anode=4'b1111, frame_tick=0
  - Asserting reset mid-slot blanks the display in the same instant.
- Counter: increments every clk edge; wraps 2^COUNT_BITS-1 -> 0 with no stall.
- Digit select: sel = counter[COUNT_BITS-1:COUNT_BITS-2]; 0,1,2,3 -> anode 1110,1101,1011,0111.
- Decode:
  - Nibble data[4*sel+3:4*sel] goes through the hex decoder (active-low).
  - Values: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E (hex, dp bit off).
  - segment[7] = ~dp[sel].
- Blanking: if blank[sel]=1, the registered result for that slot is anode=4'b1111 and segment=8'hFF, regardless of dp.
- Latency:
  - segment/anode are registered from the combinational decode of the pre-increment counter value, so they lag the counter by one clock.
  - A change on data, blank or dp appears on the outputs at the next clk edge when it affects the current slot.
  - Otherwise it appears at the start of that digit's next slot.
- Anode sequencing: exactly one anode is low in any cycle (unless blanked). There is never more than one low, and no all-on glitch at slot boundaries, because outputs are registered.
- frame_tick: registered high for the one cycle after the edge where the counter transitions 2^COUNT_BITS-1 -> 0. It aligns with the first registered digit-0 output.
- First edge after reset release: counter 0->1; outputs show digit 0. frame_tick stays 0 until the first wrap.
- Inputs are synchronous to clk. No synchronisers are inside; switch inputs are synchronised upstream.

Decomposition:
- Package seven_seg_pkg:
  - SEG_OFF=8'hFF, ANODE_OFF=4'b1111.
  - ANODE_SEL[4] one-cold constants.
  - typedef logic [3:0] nibble_t.
- Sub-module: reuse the existing combinational hex decoder seven_segment (data[3:0] -> segment[6:0]), instanced once on the muxed nibble.
- Counter, mux, blank/dp logic and output registers live in this module.

Test Plan (COUNT_BITS=4, 4-cycle slots, 16-cycle frame):
1. Reset held, data=16'h1234 -> segment=FF, anode=1111, frame_tick=0. Release: within 16 cycles the bench sees anode 1110/seg 99 (4), 1101/B0 (3), 1011/A4 (2), 0111/F9 (1), 4 cycles each, in that order.
2. data=16'hF0A8, free run two frames -> digits read 80, 88, C0, 8E. frame_tick is high exactly once per 16 cycles, coincident with the first anode=1110 cycle.
3. blank=4'b0101, dp=4'b0001, data=16'h8888 -> slots 0 and 2 show anode=1111/seg=FF (dp ignored). Slots 1 and 3 show 1101/80 and 0111/80.
4. dp=4'b1010, data=0 -> digit 1 and 3 seg=40, digits 0 and 2 seg=C0.
5. During slot 1, change data[7:4] 3->7 -> segment changes B0->F8 one clk edge later while anode stays 1101.
6. Assert reset asynchronously mid-slot 2 (between edges) -> anode=1111 and segment=FF immediately. After release the sequence restarts at digit 0 with counter from 0.
